edit_button_conditioner: RTL and testbench

Front-end for the clock/timer/date edit path: conditions the four raw push-buttons and emits the single-cycle `push_up` / `push_down` strobes and the `counterlr` field cursor consumed by the up/down adjustment counters.
- Per button: 2-flop synchroniser, debounce filter, press-edge detection.
- Auto-repeat for a held up/down button.
- Left/right buttons move `counterlr` across the fields of the active edit mode.

---
 rtl/edit_button_conditioner_if.sv | 31 +++
 rtl/edit_button_conditioner.sv | 183 ++++++++++++++++++
 tb/tb_edit_button_conditioner.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/edit_button_conditioner_if.sv
// ============================================================================
// edit_button_conditioner_if: raw buttons and mode selects in, strobes/cursor out
// Rev 1.0
// ============================================================================
`default_nettype none

interface edit_button_conditioner_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       sw;
  logic       stime;
  logic       date;
  logic       timer;
  logic       push_up;
  logic       push_down;
  logic [4:0] counterlr;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, sw, stime, date, timer,
    input  push_up, push_down, counterlr
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, sw, stime, date, timer,
    output push_up, push_down, counterlr
  );
endinterface

`default_nettype wire

// File: rtl/edit_button_conditioner.sv
// ============================================================================
// edit_button_conditioner: button sync/debounce, up/down auto-repeat, field cursor
// Rev 1.0
// ============================================================================
`default_nettype none

module edit_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic                     clk,
  input  logic                     swreset_n,
  edit_button_conditioner_if.slave bus
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_NONE  = 2'd0,
    MODE_STIME = 2'd1,
    MODE_DATE  = 2'd2,
    MODE_TIMER = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HOLD_UP = 3'd1,
    S_HOLD_DN = 3'd2,
    S_REP_UP  = 3'd3,
    S_REP_DN  = 3'd4
  } state_t;

  // Button index order: 0 up, 1 down, 2 left, 3 right.
  logic [3:0] raw;
  logic [3:0] sync_lvl;
  logic [3:0] deb;
  logic [3:0] deb_d;
  logic [3:0] armed;
  logic [3:0] rise;

  assign raw = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    logic          s1;
    logic          s2;
    logic          lvl;
    logic [DW-1:0] cnt;

    always_ff @(posedge clk or negedge swreset_n) begin
      if (!swreset_n) begin
        s1  <= 1'b0;
        s2  <= 1'b0;
        lvl <= 1'b0;
        cnt <= '0;
      end else begin
        s1 <= raw[i];
        s2 <= s1;
        if (s2 != lvl) begin
          if (cnt == DEB_LAST) begin
            lvl <= ~lvl;
            cnt <= '0;
          end else begin
            cnt <= cnt + DW'(1);
          end
        end else begin
          cnt <= '0;
        end
      end
    end

    assign sync_lvl[i] = s2;
    assign deb[i]      = lvl;
  end

  assign rise = deb & ~deb_d & armed;

  mode_t         mode_sel;
  mode_t         mode_q;
  mode_t         mode_act;
  state_t        state;
  logic [TW-1:0] tcnt;
  logic          up_strobe;
  logic          down_strobe;
  logic [4:0]    cursor;
  logic [4:0]    lo;
  logic [4:0]    hi;
  logic          owner_up;
  logic          owner_held;
  logic          in_hold;

  always_comb begin
    mode_sel = MODE_NONE;
    if (bus.sw) begin
      if (bus.stime)      mode_sel = MODE_STIME;
      else if (bus.date)  mode_sel = MODE_DATE;
      else if (bus.timer) mode_sel = MODE_TIMER;
    end
    lo         = (mode_q == MODE_DATE) ? 5'd4 : 5'd1;
    hi         = lo + 5'd2;
    owner_up   = (state == S_HOLD_UP) || (state == S_REP_UP);
    in_hold    = (state == S_HOLD_UP) || (state == S_HOLD_DN);
    owner_held = owner_up ? deb[0] : deb[1];
  end

  // mode_q samples the selects; a mismatch with mode_act marks a mode change.
  always_ff @(posedge clk or negedge swreset_n) begin
    if (!swreset_n) begin
      deb_d       <= '0;
      armed       <= '1;
      mode_q      <= MODE_NONE;
      mode_act    <= MODE_NONE;
      state       <= S_IDLE;
      tcnt        <= '0;
      up_strobe   <= 1'b0;
      down_strobe <= 1'b0;
      cursor      <= '0;
    end else begin
      deb_d       <= deb;
      mode_q      <= mode_sel;
      mode_act    <= mode_q;
      up_strobe   <= 1'b0;
      down_strobe <= 1'b0;
      armed       <= armed | ~(deb | sync_lvl);

      if (mode_q != mode_act) begin
        armed  <= '0;
        cursor <= (mode_q == MODE_NONE) ? 5'd0 : lo;
        state  <= S_IDLE;
        tcnt   <= '0;
      end else if (mode_q == MODE_NONE) begin
        cursor <= '0;
        state  <= S_IDLE;
        tcnt   <= '0;
      end else begin
        if (rise[3] && !rise[2])
          cursor <= (cursor == hi) ? lo : cursor + 5'd1;
        else if (rise[2] && !rise[3])
          cursor <= (cursor == lo) ? hi : cursor - 5'd1;

        case (state)
          S_IDLE: begin
            tcnt <= '0;
            if (rise[0] && !rise[1]) begin
              up_strobe <= 1'b1;
              state     <= S_HOLD_UP;
            end else if (rise[1] && !rise[0]) begin
              down_strobe <= 1'b1;
              state       <= S_HOLD_DN;
            end
          end
          S_HOLD_UP, S_HOLD_DN, S_REP_UP, S_REP_DN: begin
            if (!owner_held) begin
              state <= S_IDLE;
              tcnt  <= '0;
            end else if (tcnt == (in_hold ? HOLD_LAST : REP_LAST)) begin
              tcnt <= '0;
              if (owner_up) up_strobe   <= 1'b1;
              else          down_strobe <= 1'b1;
              if (in_hold) state <= owner_up ? S_REP_UP : S_REP_DN;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.push_up   = up_strobe;
  assign bus.push_down = down_strobe;
  assign bus.counterlr = cursor;

endmodule

`default_nettype wire

// File: tb/tb_edit_button_conditioner.sv
// ============================================================================
// tb_edit_button_conditioner: strobe scoreboard plus table-driven cursor checks
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_edit_button_conditioner;

  localparam int D = 4;
  localparam int H = 20;
  localparam int R = 8;
  localparam int LAT = D + 3;  // input set after edge k -> strobe visible after edge k+LAT

  logic clk = 1'b0;
  logic swreset_n = 1'b0;

  edit_button_conditioner_if bus ();

  edit_button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .REPEAT_CYCLES  (R)
  ) dut (
    .clk      (clk),
    .swreset_n(swreset_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int at;
    bit up;
  } strobe_t;

  typedef struct {
    bit sw;
    bit stime;
    bit date;
    bit timer;
    bit right;
    bit left;
    int exp;
  } vec_t;

  strobe_t exp_q[$];
  vec_t    vecs[15];
  int      n_checks = 0;
  int      n_fail = 0;
  bit      mon_en = 1'b0;
  int      k;
  int      t0;

  always @(negedge clk) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL strobe_missing: no strobe observed, required %s at cycle %0d",
                 exp_q[0].up ? "push_up" : "push_down", exp_q[0].at);
        void'(exp_q.pop_front());
      end
      if (bus.push_up || bus.push_down) begin
        n_checks++;
        if (exp_q.size() == 0 || exp_q[0].at != cyc ||
            {bus.push_up, bus.push_down} != (exp_q[0].up ? 2'b10 : 2'b01)) begin
          n_fail++;
          $display("FAIL strobe_unexpected: got up=%0b down=%0b at cycle %0d, required %s",
                   bus.push_up, bus.push_down, cyc,
                   (exp_q.size() == 0) ? "no strobe" :
                   $sformatf("%s at cycle %0d", exp_q[0].up ? "push_up" : "push_down", exp_q[0].at));
        end else begin
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_strobe(input int at, input bit up);
    strobe_t s;
    s.at = at;
    s.up = up;
    exp_q.push_back(s);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic set_mode(input bit s, input bit st, input bit dt, input bit tm);
    bus.sw    = s;
    bus.stime = st;
    bus.date  = dt;
    bus.timer = tm;
  endtask

  initial begin
    vecs[0]  = '{1, 0, 1, 0, 0, 0, 4};
    vecs[1]  = '{1, 0, 1, 0, 1, 0, 5};
    vecs[2]  = '{1, 0, 1, 0, 1, 0, 6};
    vecs[3]  = '{1, 0, 1, 0, 1, 0, 4};
    vecs[4]  = '{1, 0, 1, 0, 0, 1, 6};
    vecs[5]  = '{1, 1, 0, 0, 0, 0, 1};
    vecs[6]  = '{1, 1, 0, 0, 1, 1, 1};
    vecs[7]  = '{1, 1, 0, 0, 0, 1, 3};
    vecs[8]  = '{1, 1, 0, 0, 1, 0, 1};
    vecs[9]  = '{1, 0, 0, 1, 0, 0, 1};
    vecs[10] = '{1, 0, 0, 1, 1, 0, 2};
    vecs[11] = '{0, 0, 0, 1, 1, 0, 0};
    vecs[12] = '{1, 0, 1, 1, 0, 0, 4};
    vecs[13] = '{1, 1, 1, 1, 0, 0, 1};
    vecs[14] = '{1, 1, 1, 1, 0, 1, 3};

    bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0; bus.btn_right = 0;
    set_mode(1, 1, 0, 0);

    // reset state
    #2;
    check("reset_push_up", bus.push_up, 0);
    check("reset_push_down", bus.push_down, 0);
    check("reset_counterlr", bus.counterlr, 0);
    tick(2);
    swreset_n = 1'b1;
    mon_en = 1'b1;
    tick(3);
    check("stime_entry_counterlr", bus.counterlr, 1);

    // clean single press, released before hold expiry
    k = cyc;
    bus.btn_up = 1;
    expect_strobe(k + LAT, 1);
    tick(15);
    bus.btn_up = 0;
    tick(12);

    // bounce rejection, then one clean 6-cycle hold
    for (int i = 0; i < 7; i++) begin
      bus.btn_down = 1; tick(3);
      bus.btn_down = 0; tick(3);
    end
    k = cyc;
    bus.btn_down = 1;
    expect_strobe(k + LAT, 0);
    tick(6);
    bus.btn_down = 0;
    tick(15);

    // auto-repeat
    k = cyc;
    t0 = k + LAT;
    bus.btn_up = 1;
    expect_strobe(t0, 1);
    for (int i = 0; i < 5; i++) expect_strobe(t0 + H + i * R, 1);
    tick(LAT + 50);
    bus.btn_up = 0;
    tick(25);

    // cursor table
    for (int i = 0; i < 15; i++) begin
      set_mode(vecs[i].sw, vecs[i].stime, vecs[i].date, vecs[i].timer);
      tick(4);
      if (vecs[i].right || vecs[i].left) begin
        bus.btn_right = vecs[i].right;
        bus.btn_left  = vecs[i].left;
        tick(8);
        bus.btn_right = 0;
        bus.btn_left  = 0;
        tick(8);
      end
      check($sformatf("cursor_vec%0d", i), bus.counterlr, vecs[i].exp);
    end

    // mode change while held
    set_mode(1, 1, 0, 0);
    tick(4);
    k = cyc;
    bus.btn_up = 1;
    expect_strobe(k + LAT, 1);
    expect_strobe(k + LAT + H, 1);
    expect_strobe(k + LAT + H + R, 1);
    tick(LAT + H + R + 3);
    bus.sw = 0;
    tick(4);
    check("sw_drop_counterlr", bus.counterlr, 0);
    bus.sw = 1;
    tick(40);
    check("sw_raise_counterlr", bus.counterlr, 1);
    bus.btn_up = 0;
    tick(12);
    k = cyc;
    bus.btn_up = 1;
    expect_strobe(k + LAT, 1);
    tick(12);
    bus.btn_up = 0;
    tick(12);

    // simultaneous up and down: no strobe expected
    bus.btn_up = 1;
    bus.btn_down = 1;
    tick(14);
    bus.btn_up = 0;
    bus.btn_down = 0;
    tick(12);

    // async reset mid-hold
    k = cyc;
    bus.btn_up = 1;
    expect_strobe(k + LAT, 1);
    tick(12);
    check("pre_reset_counterlr", bus.counterlr, 1);
    swreset_n = 1'b0;
    #1;
    check("async_reset_counterlr", bus.counterlr, 0);
    check("async_reset_push_up", bus.push_up, 0);
    check("async_reset_push_down", bus.push_down, 0);
    tick(3);
    swreset_n = 1'b1;
    tick(40);
    check("post_reset_counterlr", bus.counterlr, 1);
    bus.btn_up = 0;
    tick(12);
    k = cyc;
    bus.btn_up = 1;
    expect_strobe(k + LAT, 1);
    tick(12);
    bus.btn_up = 0;
    tick(15);

    while (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL strobe_never_seen: none, required %s at cycle %0d",
               exp_q[0].up ? "push_up" : "push_down", exp_q[0].at);
      void'(exp_q.pop_front());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
